stage_decode_sb: RTL and testbench
==================================

# stage_decode_sb

Parametrised successor to the in-order decode stage. It uses valid/ready handshakes on both sides, keeps a per-register pending-write scoreboard, and resolves operands across `NFWD` forwarding channels. It sits between fetch and execute; the register file and the writeback path are external. It reuses the existing `decode` and `privileged` modules combinationally.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `NREG`, 16, architectural registers; `AW = $clog2(NREG)`.
- `NFWD`, 2, forwarding channels; index 0 is the youngest and has highest priority.
- `SBW`, 2, scoreboard counter width; at most `2**SBW-1` writes outstanding per register.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1
  - `rst` in 1
- Fetch side:
  - `in_valid` in 1; `in_ready` out 1
  - `in_pc` in XLEN; `in_instr` in 32
- Register-file read ports (combinational read), for the predicate, A, B and memory-data operands:
  - `rf_addr_p`, `rf_addr_a`, `rf_addr_b`, `rf_addr_m` out AW
  - `rf_data_p`, `rf_data_a`, `rf_data_b`, `rf_data_m` in XLEN
- Forwarding and retirement:
  - `fwd_valid` in NFWD; `fwd_addr` in NFWD*AW; `fwd_data` in NFWD*XLEN
  - `wb_valid` in 1; `wb_addr` in AW, retirement of one write (scoreboard decrement)
- Execute side:
  - `out_valid` out 1; `out_ready` in 1
  - `pc`, `reg_a`, `reg_b`, `reg_m` out XLEN
  - `dest` out AW; `aluop` out 4; `mem`, `mem_write`, `jump` out 1
- Status:
  - `discard` out 1, combinational; tells fetch to flush in the cycle a jump issues.
  - `stall` out 1, hazard indication for performance counters.

## Operation
- **Predicate.** `pred = (P == 0) ^ in_instr[23]`. P is `rf_addr_p = in_instr[31:28]`, resolved like any other source.
- **Source resolution.** Sources are p, a, b and m. For each source r ≠ 0:
  - `pend[r] == 0`: take the rf data.
  - `pend[r] != 0`: take `fwd_data[i]` from the lowest i with `fwd_valid[i] && fwd_addr[i] == r`.
  - `pend[r] != 0` with no match: hazard.
  - Register 0 is never tracked and never hazards.
- **Operand formation.** Operand, immediate and AUI formation are unchanged from the current stage:
  - upper immediate: shift-by-11, or sign-extend then ×4;
  - lower immediate: 11-bit sign-extended;
  - AUI uses `in_pc` as the base.
- **Acceptance.**
  - `space = !out_valid || out_ready`.
  - `hazard = (any source unresolved) || (pred && dest != 0 && pend[dest] == max)`.
  - `in_ready = space && (squash || !hazard)`.
  - `fire = in_valid && in_ready`.
- **On fire:**
  - **squash set:** the instruction is dropped and squash clears.
  - **pred false:** the instruction is consumed. Nothing is emitted and the scoreboard is untouched.
  - **otherwise (issue):** latch all outputs and set `out_valid = 1`. If `dest != 0`, `pend[dest]` increments. If `is_jump`, assert `discard` this cycle and set squash.
- **Output register.**
  - Holds while `out_valid && !out_ready`.
  - With `out_ready` high and no issue, `out_valid` falls to 0.
- **Scoreboard update.** `wb_valid` decrements `pend[wb_addr]`, saturating at 0.
  - Increment and decrement of the same register in one cycle leaves it unchanged.
  - The hazard check uses the registered count. Integration ties the writeback result onto channel `NFWD-1`.
- **Reset values.** `out_valid=0`, `jump=0`, `mem=0`, `mem_write=0`, `dest=0`, `aluop=0`, `pc/reg_a/reg_b/reg_m=0`, all `pend=0`, `squash=0`.
  - Reset mid-operation discards the in-flight output and all pending counts.

## Timing
- Latency: 1 cycle from `fire` to `out_valid`. Full throughput (1 per cycle) when hazard-free and `out_ready` is held high.
- `in_ready`, `stall` and `discard` are combinational from the inputs and state. No combinational path from `out_ready` to `out_*`.
- A scoreboard increment is visible to the next cycle's hazard check.
- A forwarding hit resolves in the same cycle.
- `squash` covers exactly one subsequent accepted instruction.

## Structure
- Package `decode_pkg`: `XLEN_DEFAULT`, the aluop enum, the predicate bit index (23), and the immediate widths (21/11).
- Sub-module `scoreboard`: `NREG` × `SBW` counters with issue port, retire port, per-source query and saturation flag.
- Top level: resolution muxes, handshake logic and output register.

## Test plan
- **Back-to-back independent ALU ops**, `out_ready=1` → one output per cycle; `out_valid` rises 1 cycle after the first fire.
- **RAW hazard.** Issue `r3 ← r1+r2`, then `r4 ← r3+r1` with no forward → `in_ready=0` and `stall=1`. Raising `fwd_valid[0]`, `fwd_addr[0]=3`, `fwd_data[0]=0x55` → fires, `reg_a=0x55`.
- **Priority and simultaneous events.** Channel 0 and channel 1 both match r5 with different data → channel 0 value used. Issue to r5 and `wb_addr=5` in the same cycle → `pend[5]` unchanged.
- **Saturation.** `SBW=2`: three outstanding writes to r7, then a fourth → stall until one `wb_valid` for r7.
- **Predication and jump.** Predicated-off instruction → consumed, no output, no scoreboard change. Jump issues → `discard=1` that cycle and the next accepted instruction is dropped.
- **Backpressure and reset.** `out_ready=0` for 3 cycles → outputs stable and `in_ready=0`. Async `rst` mid-stream → `out_valid=0` immediately and all counts 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: aluop encodings, instruction field layout
// and the combinational field decoder used by the decode stage.
package decode_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int PRED_BIT     = 23;
    localparam int UIMM_W       = 21;
    localparam int LIMM_W       = 11;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_e;

    typedef enum logic [1:0] {
        K_ALU = 2'd0,
        K_MEM = 2'd1,
        K_LUI = 2'd2,
        K_JMP = 2'd3
    } kind_e;

    typedef struct packed {
        kind_e              kind;
        logic               use_imm;
        logic               mem_write;
        logic [3:0]         aluop;
        logic [3:0]         rd;
        logic [3:0]         rp;
        logic [3:0]         ra;
        logic [3:0]         rb;
        logic [3:0]         rm;
        logic [UIMM_W-1:0]  uimm;
        logic [LIMM_W-1:0]  limm;
    } dec_t;

    // Unused source fields decode to r0 so they can never raise a hazard.
    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        d         = '0;
        d.kind    = kind_e'(i[22:21]);
        d.rp      = i[31:28];
        d.rd      = i[27:24];
        d.use_imm = i[20];
        d.uimm    = i[UIMM_W-1:0];
        d.limm    = i[LIMM_W-1:0];
        d.aluop   = ALU_ADD;
        unique case (d.kind)
            K_ALU: begin
                d.ra    = i[19:16];
                d.rb    = i[20] ? 4'd0 : i[11:8];
                d.aluop = i[15:12];
            end
            K_MEM: begin
                d.ra        = i[19:16];
                d.rm        = i[20] ? i[15:12] : 4'd0;
                d.mem_write = i[20];
                d.rd        = i[20] ? 4'd0 : i[27:24];
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/scoreboard.sv
// Per-register pending-write counters with one issue port, one retire
// port, NQ busy queries and a saturation flag for the destination.
module scoreboard #(
    parameter int NREG = 16,
    parameter int SBW  = 2,
    parameter int NQ   = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           iss_valid,
    input  logic [AW-1:0]  iss_addr,
    input  logic           ret_valid,
    input  logic [AW-1:0]  ret_addr,
    input  logic [NQ*AW-1:0] q_addr,
    output logic [NQ-1:0]  q_busy,
    input  logic [AW-1:0]  sat_addr,
    output logic           sat
);

    localparam logic [SBW-1:0] MAX = '1;

    logic [SBW-1:0] pend_q [NREG];
    logic [SBW-1:0] pend_d [NREG];
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;

    // Same-cycle issue and retire to one register cancel out.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 0; r < NREG; r++) begin
            inc[r]    = iss_valid && (iss_addr == AW'(r));
            dec[r]    = ret_valid && (ret_addr == AW'(r));
            pend_d[r] = pend_q[r];
            if (r == 0)
                pend_d[r] = '0;
            else if (inc[r] && !dec[r])
                pend_d[r] = pend_q[r] + 1'b1;
            else if (dec[r] && !inc[r] && pend_q[r] != '0)
                pend_d[r] = pend_q[r] - 1'b1;
        end
    end

    always_comb begin
        q_busy = '0;
        for (int q = 0; q < NQ; q++)
            q_busy[q] = pend_q[q_addr[q*AW +: AW]] != '0;
        sat = pend_q[sat_addr] == MAX;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                pend_q[r] <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/stage_decode_sb.sv
// Decode stage with valid/ready handshakes, pending-write scoreboard
// and multi-channel operand forwarding.
module stage_decode_sb
    import decode_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = 16,
    parameter int NFWD = 2,
    parameter int SBW  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [31:0]        in_instr,
    output logic [AW-1:0]      rf_addr_p,
    output logic [AW-1:0]      rf_addr_a,
    output logic [AW-1:0]      rf_addr_b,
    output logic [AW-1:0]      rf_addr_m,
    input  logic [XLEN-1:0]    rf_data_p,
    input  logic [XLEN-1:0]    rf_data_a,
    input  logic [XLEN-1:0]    rf_data_b,
    input  logic [XLEN-1:0]    rf_data_m,
    input  logic [NFWD-1:0]    fwd_valid,
    input  logic [NFWD*AW-1:0] fwd_addr,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic               wb_valid,
    input  logic [AW-1:0]      wb_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    reg_a,
    output logic [XLEN-1:0]    reg_b,
    output logic [XLEN-1:0]    reg_m,
    output logic [AW-1:0]      dest,
    output logic [3:0]         aluop,
    output logic               mem,
    output logic               mem_write,
    output logic               jump,
    output logic               discard,
    output logic               stall
);

    dec_t            dec;
    logic [AW-1:0]   src_addr [4];
    logic [XLEN-1:0] src_rf   [4];
    logic [XLEN-1:0] src_val  [4];
    logic [3:0]      src_unres;
    logic [3:0]      src_busy;
    logic [4*AW-1:0] q_addr;
    logic [AW-1:0]   dest_c;
    logic            dest_sat;
    logic            pred, hazard, space, fire, issue;
    logic [XLEN-1:0] opa, opb, limm_x, uimm_x;

    logic            out_valid_q, out_valid_d, squash_q, squash_d;
    logic [XLEN-1:0] pc_q, pc_d, reg_a_q, reg_a_d;
    logic [XLEN-1:0] reg_b_q, reg_b_d, reg_m_q, reg_m_d;
    logic [AW-1:0]   dest_q, dest_d;
    logic [3:0]      aluop_q, aluop_d;
    logic            mem_q, mem_d, mem_write_q, mem_write_d;
    logic            jump_q, jump_d;

    assign dec         = decode(in_instr);
    assign dest_c      = AW'(dec.rd);
    assign src_addr[0] = AW'(dec.rp);
    assign src_addr[1] = AW'(dec.ra);
    assign src_addr[2] = AW'(dec.rb);
    assign src_addr[3] = AW'(dec.rm);
    assign src_rf[0]   = rf_data_p;
    assign src_rf[1]   = rf_data_a;
    assign src_rf[2]   = rf_data_b;
    assign src_rf[3]   = rf_data_m;
    assign rf_addr_p   = src_addr[0];
    assign rf_addr_a   = src_addr[1];
    assign rf_addr_b   = src_addr[2];
    assign rf_addr_m   = src_addr[3];
    assign q_addr      = {src_addr[3], src_addr[2], src_addr[1], src_addr[0]};

    scoreboard #(.NREG(NREG), .SBW(SBW), .NQ(4), .AW(AW)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_valid(issue && dest_c != '0),
        .iss_addr (dest_c),
        .ret_valid(wb_valid),
        .ret_addr (wb_addr),
        .q_addr   (q_addr),
        .q_busy   (src_busy),
        .sat_addr (dest_c),
        .sat      (dest_sat)
    );

    // Scan channels oldest-first so the youngest match overwrites last.
    always_comb begin
        src_unres = '0;
        for (int s = 0; s < 4; s++) begin
            src_val[s] = src_rf[s];
            if (src_busy[s]) begin
                src_unres[s] = 1'b1;
                for (int i = NFWD - 1; i >= 0; i--) begin
                    if (fwd_valid[i] && fwd_addr[i*AW +: AW] == src_addr[s]) begin
                        src_val[s]   = fwd_data[i*XLEN +: XLEN];
                        src_unres[s] = 1'b0;
                    end
                end
            end
        end
    end

    assign limm_x = {{(XLEN-LIMM_W){dec.limm[LIMM_W-1]}}, dec.limm};
    assign uimm_x = {{(XLEN-UIMM_W){dec.uimm[UIMM_W-1]}}, dec.uimm};

    always_comb begin
        opa = (dec.kind == K_JMP) ? in_pc : src_val[1];
        unique case (dec.kind)
            K_ALU:   opb = dec.use_imm ? limm_x : src_val[2];
            K_MEM:   opb = limm_x;
            K_LUI:   opb = XLEN'({dec.uimm, {LIMM_W{1'b0}}});
            default: opb = uimm_x << 2;
        endcase
    end

    assign pred     = (src_val[0] == '0) ^ in_instr[PRED_BIT];
    assign hazard   = (|src_unres) || (pred && dest_c != '0 && dest_sat);
    assign space    = !out_valid_q || out_ready;
    assign in_ready = space && (squash_q || !hazard);
    assign fire     = in_valid && in_ready;
    assign issue    = fire && !squash_q && pred;
    assign discard  = issue && dec.kind == K_JMP;
    assign stall    = in_valid && space && !squash_q && hazard;

    always_comb begin
        out_valid_d = issue ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        squash_d    = fire ? discard : squash_q;
        pc_d        = pc_q;
        reg_a_d     = reg_a_q;
        reg_b_d     = reg_b_q;
        reg_m_d     = reg_m_q;
        dest_d      = dest_q;
        aluop_d     = aluop_q;
        mem_d       = mem_q;
        mem_write_d = mem_write_q;
        jump_d      = jump_q;
        if (issue) begin
            pc_d        = in_pc;
            reg_a_d     = opa;
            reg_b_d     = opb;
            reg_m_d     = src_val[3];
            dest_d      = dest_c;
            aluop_d     = dec.aluop;
            mem_d       = dec.kind == K_MEM;
            mem_write_d = dec.mem_write;
            jump_d      = dec.kind == K_JMP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            squash_q    <= 1'b0;
            pc_q        <= '0;
            reg_a_q     <= '0;
            reg_b_q     <= '0;
            reg_m_q     <= '0;
            dest_q      <= '0;
            aluop_q     <= '0;
            mem_q       <= 1'b0;
            mem_write_q <= 1'b0;
            jump_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            squash_q    <= squash_d;
            pc_q        <= pc_d;
            reg_a_q     <= reg_a_d;
            reg_b_q     <= reg_b_d;
            reg_m_q     <= reg_m_d;
            dest_q      <= dest_d;
            aluop_q     <= aluop_d;
            mem_q       <= mem_d;
            mem_write_q <= mem_write_d;
            jump_q      <= jump_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pc        = pc_q;
    assign reg_a     = reg_a_q;
    assign reg_b     = reg_b_q;
    assign reg_m     = reg_m_q;
    assign dest      = dest_q;
    assign aluop     = aluop_q;
    assign mem       = mem_q;
    assign mem_write = mem_write_q;
    assign jump      = jump_q;

endmodule

// File: tb/tb_stage_decode_sb.sv
// Directed bench for stage_decode_sb: handshake, hazards, forwarding,
// saturation, predication, jump squash, backpressure and async reset.
module tb_stage_decode_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_instr;
    logic [3:0]  rf_addr_p, rf_addr_a, rf_addr_b, rf_addr_m;
    logic [31:0] rf_data_p, rf_data_a, rf_data_b, rf_data_m;
    logic [1:0]  fwd_valid;
    logic [7:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic        out_valid, out_ready;
    logic [31:0] pc, reg_a, reg_b, reg_m;
    logic [3:0]  dest, aluop;
    logic        mem, mem_write, jump, discard, stall;

    logic [31:0] rf [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rf_data_p = rf[rf_addr_p];
    assign rf_data_a = rf[rf_addr_a];
    assign rf_data_b = rf[rf_addr_b];
    assign rf_data_m = rf[rf_addr_m];

    stage_decode_sb dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr),
        .rf_addr_p(rf_addr_p), .rf_addr_a(rf_addr_a),
        .rf_addr_b(rf_addr_b), .rf_addr_m(rf_addr_m),
        .rf_data_p(rf_data_p), .rf_data_a(rf_data_a),
        .rf_data_b(rf_data_b), .rf_data_m(rf_data_m),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_addr(wb_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc(pc), .reg_a(reg_a), .reg_b(reg_b), .reg_m(reg_m),
        .dest(dest), .aluop(aluop), .mem(mem), .mem_write(mem_write),
        .jump(jump), .discard(discard), .stall(stall)
    );

    function automatic logic [31:0] rr(input logic [3:0] rd, ra, rb, op);
        return {4'd0, rd, 1'b0, 2'b00, 1'b0, ra, op, rb, 8'h00};
    endfunction

    function automatic logic [31:0] ri(input logic [3:0] rd, ra, op,
                                       input logic [10:0] imm);
        return {4'd0, rd, 1'b0, 2'b00, 1'b1, ra, op, 1'b0, imm};
    endfunction

    function automatic logic [31:0] lui(input logic [3:0] rd, input logic [20:0] imm);
        return {4'd0, rd, 1'b0, 2'b10, imm};
    endfunction

    function automatic logic [31:0] jmp(input logic [3:0] rd, input logic [20:0] imm);
        return {4'd0, rd, 1'b0, 2'b11, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            rf[i] = (i == 0) ? 32'h0 : 32'h100 + 32'(i);
        rst = 1'b1;
        in_valid = 1'b0; in_pc = 32'h1000; in_instr = 32'h0;
        fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
        wb_valid = 1'b0; wb_addr = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_dest", 32'(dest), 0);
        chk("rst_reg_a", reg_a, 0);
        chk("rst_jump", 32'(jump), 0);
        rst = 1'b0;
        tick();

        // back-to-back independent ops
        in_valid = 1'b1; in_instr = rr(4'd1, 4'd2, 4'd3, 4'd0);
        #1 chk("b2b_ready0", 32'(in_ready), 1);
        chk("b2b_nov", 32'(out_valid), 0);
        tick();
        chk("b2b_v0", 32'(out_valid), 1);
        chk("b2b_a0", reg_a, 32'h102);
        chk("b2b_b0", reg_b, 32'h103);
        chk("b2b_d0", 32'(dest), 1);
        chk("b2b_pc0", pc, 32'h1000);
        in_instr = ri(4'd2, 4'd4, 4'd4, 11'h7FF);
        #1 chk("b2b_ready1", 32'(in_ready), 1);
        tick();
        chk("b2b_v1", 32'(out_valid), 1);
        chk("b2b_a1", reg_a, 32'h104);
        chk("b2b_b1", reg_b, 32'hFFFF_FFFF);
        chk("b2b_op1", 32'(aluop), 4);
        in_valid = 1'b0;
        tick();
        chk("b2b_drain", 32'(out_valid), 0);
        chk("pend1", 32'(dut.u_sb.pend_q[1]), 1);
        wb_valid = 1'b1; wb_addr = 4'd1; tick();
        wb_addr = 4'd2; tick();
        wb_valid = 1'b0;
        chk("pend1_ret", 32'(dut.u_sb.pend_q[1]), 0);
        chk("pend2_ret", 32'(dut.u_sb.pend_q[2]), 0);

        // RAW hazard resolved by forwarding channel 0
        in_valid = 1'b1; in_instr = rr(4'd3, 4'd1, 4'd2, 4'd0);
        tick();
        in_instr = rr(4'd4, 4'd3, 4'd1, 4'd0);
        #1 chk("raw_ready", 32'(in_ready), 0);
        chk("raw_stall", 32'(stall), 1);
        tick();
        fwd_valid = 2'b01; fwd_addr = {4'd0, 4'd3}; fwd_data = {32'h0, 32'h55};
        #1 chk("raw_fwd_ready", 32'(in_ready), 1);
        chk("raw_fwd_stall", 32'(stall), 0);
        tick();
        chk("raw_a", reg_a, 32'h55);
        chk("raw_b", reg_b, 32'h101);
        chk("raw_d", 32'(dest), 4);
        fwd_valid = '0;

        // channel priority, then simultaneous issue/retire
        in_instr = lui(4'd5, 21'h1);
        tick();
        chk("lui_b", reg_b, 32'h800);
        in_instr = rr(4'd6, 4'd5, 4'd5, 4'd1);
        fwd_valid = 2'b11; fwd_addr = {4'd5, 4'd5};
        fwd_data = {32'hBBBB, 32'hAAAA};
        #1 chk("prio_ready", 32'(in_ready), 1);
        tick();
        chk("prio_a", reg_a, 32'hAAAA);
        chk("prio_b", reg_b, 32'hAAAA);
        fwd_valid = '0;
        in_instr = lui(4'd5, 21'h0);
        wb_valid = 1'b1; wb_addr = 4'd5;
        tick();
        chk("simul_pend5", 32'(dut.u_sb.pend_q[5]), 1);
        in_valid = 1'b0;
        tick();
        wb_valid = 1'b0;
        chk("pend5_ret", 32'(dut.u_sb.pend_q[5]), 0);

        // saturation on r7
        in_valid = 1'b1; in_instr = lui(4'd7, 21'h3);
        tick(); tick(); tick();
        chk("sat_pend7", 32'(dut.u_sb.pend_q[7]), 3);
        #1 chk("sat_ready", 32'(in_ready), 0);
        chk("sat_stall", 32'(stall), 1);
        wb_valid = 1'b1; wb_addr = 4'd7;
        #1 chk("sat_ready_wb", 32'(in_ready), 0);
        tick();
        wb_valid = 1'b0;
        chk("sat_pend7_dec", 32'(dut.u_sb.pend_q[7]), 2);
        #1 chk("sat_ready_after", 32'(in_ready), 1);
        tick();
        chk("sat_pend7_full", 32'(dut.u_sb.pend_q[7]), 3);
        chk("sat_issue_v", 32'(out_valid), 1);

        // predicated off: r9 nonzero, invert bit clear
        in_instr = {4'd9, 4'd8, 1'b0, 2'b00, 1'b0, 4'd1, 4'd0, 4'd2, 8'h00};
        #1 chk("pred_ready", 32'(in_ready), 1);
        tick();
        chk("pred_nov", 32'(out_valid), 0);
        chk("pred_pend8", 32'(dut.u_sb.pend_q[8]), 0);

        // jump issues and squashes the next accepted instruction
        in_instr = jmp(4'd0, 21'h1F_FFFF);
        #1 chk("jmp_discard", 32'(discard), 1);
        tick();
        chk("jmp_flag", 32'(jump), 1);
        chk("jmp_a", reg_a, 32'h1000);
        chk("jmp_b", reg_b, 32'hFFFF_FFFC);
        in_instr = rr(4'd9, 4'd1, 4'd2, 4'd0);
        #1 chk("sq_ready", 32'(in_ready), 1);
        chk("sq_discard", 32'(discard), 0);
        tick();
        chk("sq_nov", 32'(out_valid), 0);
        chk("sq_pend9", 32'(dut.u_sb.pend_q[9]), 0);
        in_instr = lui(4'd10, 21'h2);
        tick();
        chk("post_sq_v", 32'(out_valid), 1);
        chk("post_sq_b", reg_b, 32'h1000);
        chk("post_sq_jump", 32'(jump), 0);

        // backpressure
        out_ready = 1'b0;
        in_instr = rr(4'd11, 4'd1, 4'd2, 4'd0);
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_ready", 32'(in_ready), 0);
            tick();
            chk("bp_v", 32'(out_valid), 1);
            chk("bp_b", reg_b, 32'h1000);
            chk("bp_d", 32'(dest), 10);
        end
        out_ready = 1'b1;
        #1 chk("bp_release", 32'(in_ready), 1);
        tick();
        chk("bp_a", reg_a, 32'h101);
        chk("bp_b2", reg_b, 32'h102);
        chk("bp_d2", 32'(dest), 11);
        in_valid = 1'b0;

        // asynchronous reset mid-stream
        #2 rst = 1'b1;
        #1 chk("arst_v", 32'(out_valid), 0);
        chk("arst_pend11", 32'(dut.u_sb.pend_q[11]), 0);
        chk("arst_pend7", 32'(dut.u_sb.pend_q[7]), 0);
        #3 rst = 1'b0;
        tick();
        in_valid = 1'b1; in_instr = rr(4'd12, 4'd11, 4'd7, 4'd0);
        #1 chk("arst_ready", 32'(in_ready), 1);
        tick();
        chk("arst_a", reg_a, 32'h10B);
        chk("arst_b", reg_b, 32'h107);
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
